// File: rtl/prefix_add_seq_pkg.sv
// Shared types for the sequential parallel-prefix adder: FSM encoding and
// the level-counter sizing helper used by the top and the prefix row.
package prefix_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEVEL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must also hold the terminal value LOG2W after the last level.
    function automatic int lvl_width(input int log2w);
        return $clog2(log2w) + 1;
    endfunction

endpackage

// File: rtl/prefix_add_seq_level.sv
// One combinational row of W (G,P) combine cells, reused for every prefix level.
// Latency: combinational. Backpressure: none, pure function of g/p/lvl.
// Bit i merges with bit i-2^lvl; bits below the span pass through unchanged.
module prefix_level #(
    parameter int W     = 16,
    parameter int LOG2W = 4,
    parameter int LVLW  = 3
) (
    input  logic [W-1:0]    g,
    input  logic [W-1:0]    p,
    input  logic [LVLW-1:0] lvl,
    output logic [W-1:0]    g_nxt,
    output logic [W-1:0]    p_nxt
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic [LOG2W-1:0] hit;
        logic [LOG2W-1:0] g_src;
        logic [LOG2W-1:0] p_src;

        // Candidate partner per level; out-of-range partners are tied off.
        for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
            if (i >= (2 ** k)) begin : g_has_partner
                assign hit[k]   = (lvl == LVLW'(k));
                assign g_src[k] = g[i - (2 ** k)];
                assign p_src[k] = p[i - (2 ** k)];
            end else begin : g_no_partner
                assign hit[k]   = 1'b0;
                assign g_src[k] = 1'b0;
                assign p_src[k] = 1'b0;
            end
        end

        logic active;
        logic g_sel;
        logic p_sel;

        assign active   = |hit;
        assign g_sel    = |(hit & g_src);
        assign p_sel    = |(hit & p_src);
        assign g_nxt[i] = active ? (g[i] | (p[i] & g_sel)) : g[i];
        assign p_nxt[i] = active ? (p[i] & p_sel) : p[i];
    end

endmodule

// File: rtl/prefix_add_seq.sv
// Multi-cycle W-bit adder: one prefix row iterated log2(W) times (Kogge-Stone result).
// Latency: out_valid rises LOG2W cycles after accept; one op in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module prefix_add_seq #(
    parameter int W     = 16,
    parameter int LOG2W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready
);
    import prefix_add_seq_pkg::*;

    localparam int LVLW = lvl_width(LOG2W);

    if (W < 2 || (2 ** LOG2W) != W) begin : g_bad_params
        $error("prefix_add_seq: W must be a power of two >= 2 and LOG2W = log2(W)");
    end

    state_t          state_q;
    state_t          state_d;
    logic [LVLW-1:0] lvl_q;
    logic [W-1:0]    g_q;
    logic [W-1:0]    p_q;
    logic [W-1:0]    praw_q;
    logic            cin_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            out_valid_q;

    logic [W-1:0]    g_nxt;
    logic [W-1:0]    p_nxt;
    logic            accept;
    logic            handoff;
    logic            last_lvl;

    prefix_level #(
        .W     (W),
        .LOG2W (LOG2W),
        .LVLW  (LVLW)
    ) u_level (
        .g     (g_q),
        .p     (p_q),
        .lvl   (lvl_q),
        .g_nxt (g_nxt),
        .p_nxt (p_nxt)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid_q && out_ready;
    assign last_lvl  = (state_q == ST_LEVEL) && (lvl_q == LVLW'(LOG2W - 1));
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_LEVEL;
            ST_LEVEL: if (last_lvl) state_d = ST_DONE;
            ST_DONE:  if (handoff)  state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lvl_q       <= '0;
            g_q         <= '0;
            p_q         <= '0;
            praw_q      <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Fold cin into bit 0 so the prefix network never sees it separately.
                praw_q <= a ^ b;
                g_q    <= {a[W-1:1] & b[W-1:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
                p_q    <= {a[W-1:1] ^ b[W-1:1], 1'b0};
                cin_q  <= cin;
                lvl_q  <= '0;
            end else if (state_q == ST_LEVEL) begin
                g_q   <= g_nxt;
                p_q   <= p_nxt;
                lvl_q <= lvl_q + LVLW'(1);
                if (last_lvl) begin
                    sum_q       <= praw_q ^ {g_nxt[W-2:0], cin_q};
                    cout_q      <= g_nxt[W-1];
                    out_valid_q <= 1'b1;
                end
            end else if (handoff) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prefix_add_seq.sv
// Randomized and directed bench for prefix_add_seq; a scoreboard queue is filled
// on every accept from an arithmetic reference and drained by a handshake monitor.
module tb_prefix_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_res  = 0;
    logic [16:0] exp_q[$];

    prefix_add_seq #(.W(16), .LOG2W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    // Scoreboard: inputs are stable around negedge, so the upcoming edge's handshakes are visible here.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, cin));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got %h with no outstanding op", {cout, sum});
                end else begin
                    chk("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input bit rand_rdy);
        bit acc;
        acc = 1'b0;
        a = x; b = y; cin = c; in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    // Called right after the accept edge; returns edges elapsed until out_valid and whether in_ready stayed low.
    task automatic wait_out(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (in_ready) busy_ok = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit busy_ok;
        bit stable;
        logic [16:0] held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum_cout", 32'({cout, sum}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Carry ripples across every bit.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(cyc, busy_ok);
        chk("t1_latency", 32'(cyc), 32'd4);
        chk("t1_sum_cout", 32'({cout, sum}), 32'h1_0000);
        take();

        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_out(cyc, busy_ok);
        chk("t2_busy_in_ready_low", 32'(busy_ok), 32'd1);
        chk("t2_sum_cout", 32'({cout, sum}), 32'h0_5556);

        // Stall the consumer while offering a competing op.
        held = {cout, sum};
        stable = 1'b1;
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if ({cout, sum} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("t3_stall_stable", 32'(stable), 32'd1);
        chk("t3_no_extra_accept", 32'(exp_q.size()), 32'd1);
        take();

        // Operands pulsed mid-computation must be ignored.
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cyc, busy_ok);
        chk("t4_sum_cout", 32'({cout, sum}), 32'h0_1000);
        take();

        // Reset while lvl==2 drops the op.
        send(16'hABCD, 16'h1111, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_sum_cout", 32'({cout, sum}), 32'd0);
        stable = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        chk("t5_no_pulse", 32'(stable), 32'd1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_out(cyc, busy_ok);
        chk("t5_fresh_sum_cout", 32'({cout, sum}), 32'h1_0000);
        take();

        n_acc = 0;
        n_res = 0;
        for (int n = 0; n < 1000; n++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
        out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_accept_count", 32'(n_acc), 32'd1000);
        chk("rand_result_count", 32'(n_res), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
